// File: rtl/mem_port_sched.sv
// Single-port data memory scheduler: pipeline (PL) port with 2-beat wide accesses and a
// DMA/debug (DM) port; PL has priority, DM preempts after a bounded wait.
module mem_port_sched #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 24,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst_n,
  input  logic                  iw_pl_req,
  input  logic                  iw_pl_we,
  input  logic                  iw_pl_wide,
  input  logic [ADDR_W-1:0]     iw_pl_addr,
  input  logic [2*DATA_W-1:0]   iw_pl_wdata,
  output logic                  ow_pl_gnt,
  output logic                  ow_pl_stall,
  output logic                  ow_pl_rvalid,
  output logic [2*DATA_W-1:0]   ow_pl_rdata,
  input  logic                  iw_dm_req,
  input  logic                  iw_dm_we,
  input  logic [ADDR_W-1:0]     iw_dm_addr,
  input  logic [DATA_W-1:0]     iw_dm_wdata,
  output logic                  ow_dm_gnt,
  output logic                  ow_dm_rvalid,
  output logic [DATA_W-1:0]     ow_dm_rdata,
  output logic                  ow_mem_en,
  output logic                  ow_mem_we,
  output logic [ADDR_W-1:0]     ow_mem_addr,
  output logic [DATA_W-1:0]     ow_mem_wdata,
  input  logic [DATA_W-1:0]     iw_mem_rdata
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {IDLE, WIDE2} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   starve_q, starve_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               wide_we_q, wide_we_d;
  logic [ADDR_W-1:0]  wide_addr_q, wide_addr_d;
  logic [DATA_W-1:0]  wide_wdata_q, wide_wdata_d;
  // Read tags ride one cycle behind the issued command, data returns the cycle after.
  logic               rd_nar_q, rd_nar_d;
  logic               rd_b1_q, rd_b1_d;
  logic               rd_b2_q, rd_b2_d;
  logic               rd_dm_q, rd_dm_d;
  logic               cap_q, cap_d;
  logic [DATA_W-1:0]  beat1_q, beat1_d;
  logic               pl_rv_q, pl_rv_d;
  logic               pl_rv_wide_q, pl_rv_wide_d;
  logic               dm_rv_q, dm_rv_d;
  logic               dm_win_c, pl_win_c;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wide_we_d    = wide_we_q;
    wide_addr_d  = wide_addr_q;
    wide_wdata_d = wide_wdata_q;
    rd_nar_d     = 1'b0;
    rd_b1_d      = 1'b0;
    rd_b2_d      = 1'b0;
    rd_dm_d      = 1'b0;

    dm_win_c = (state_q == IDLE) & iw_dm_req & ((starve_q == STARVE_LIM) | ~iw_pl_req);
    pl_win_c = (state_q == IDLE) & iw_pl_req & ~dm_win_c;

    if (dm_win_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = iw_dm_we;
      mem_addr_d  = iw_dm_addr;
      mem_wdata_d = iw_dm_wdata;
      rd_dm_d     = ~iw_dm_we;
    end else if (pl_win_c) begin
      mem_en_d    = 1'b1;
      mem_we_d    = iw_pl_we;
      mem_addr_d  = iw_pl_addr;
      mem_wdata_d = iw_pl_wdata[DATA_W-1:0];
      if (iw_pl_wide) begin
        state_d      = WIDE2;
        wide_we_d    = iw_pl_we;
        wide_addr_d  = iw_pl_addr + ADDR_W'(1);
        wide_wdata_d = iw_pl_wdata[2*DATA_W-1:DATA_W];
        rd_b1_d      = ~iw_pl_we;
      end else begin
        rd_nar_d     = ~iw_pl_we;
      end
    end

    // Second beat issues unconditionally; no grants are possible in this state.
    if (state_q == WIDE2) begin
      state_d     = IDLE;
      mem_en_d    = 1'b1;
      mem_we_d    = wide_we_q;
      mem_addr_d  = wide_addr_q;
      mem_wdata_d = wide_wdata_q;
      rd_b2_d     = ~wide_we_q;
    end

    if (dm_win_c) begin
      starve_d = '0;
    end else if (iw_dm_req && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + CNT_W'(1);
    end

    cap_d        = rd_b1_q;
    beat1_d      = cap_q ? iw_mem_rdata : beat1_q;
    pl_rv_d      = rd_nar_q | rd_b2_q;
    pl_rv_wide_d = rd_b2_q;
    dm_rv_d      = rd_dm_q;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wide_we_q    <= 1'b0;
      wide_addr_q  <= '0;
      wide_wdata_q <= '0;
      rd_nar_q     <= 1'b0;
      rd_b1_q      <= 1'b0;
      rd_b2_q      <= 1'b0;
      rd_dm_q      <= 1'b0;
      cap_q        <= 1'b0;
      beat1_q      <= '0;
      pl_rv_q      <= 1'b0;
      pl_rv_wide_q <= 1'b0;
      dm_rv_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wide_we_q    <= wide_we_d;
      wide_addr_q  <= wide_addr_d;
      wide_wdata_q <= wide_wdata_d;
      rd_nar_q     <= rd_nar_d;
      rd_b1_q      <= rd_b1_d;
      rd_b2_q      <= rd_b2_d;
      rd_dm_q      <= rd_dm_d;
      cap_q        <= cap_d;
      beat1_q      <= beat1_d;
      pl_rv_q      <= pl_rv_d;
      pl_rv_wide_q <= pl_rv_wide_d;
      dm_rv_q      <= dm_rv_d;
    end
  end

  assign ow_pl_gnt    = iw_rst_n & pl_win_c;
  assign ow_dm_gnt    = iw_rst_n & dm_win_c;
  assign ow_pl_stall  = iw_rst_n & iw_pl_req & ~pl_win_c;
  assign ow_mem_en    = mem_en_q;
  assign ow_mem_we    = mem_we_q;
  assign ow_mem_addr  = mem_addr_q;
  assign ow_mem_wdata = mem_wdata_q;
  assign ow_pl_rvalid = pl_rv_q;
  assign ow_dm_rvalid = dm_rv_q;
  // Read data comes straight from the memory in the valid cycle; zero otherwise.
  assign ow_pl_rdata  = !pl_rv_q     ? '0 :
                        pl_rv_wide_q ? {iw_mem_rdata, beat1_q} :
                                       {{DATA_W{1'b0}}, iw_mem_rdata};
  assign ow_dm_rdata  = dm_rv_q ? iw_mem_rdata : '0;

endmodule
